// File: rtl/romulator_pkg.sv
// Shared types for the VRAM snoop path: captured bus sample, FIFO entry and capture FSM states.
package romulator_pkg;

    localparam int VRAM_WINDOW_BYTES = 2048;

    typedef struct packed {
        logic [10:0] offset;
        logic [7:0]  data;
    } vram_entry_t;

    typedef struct packed {
        logic        rwb;
        logic [15:0] address;
        logic [7:0]  data;
    } cpu_bus_t;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_SAMPLE,
        CAP_QUALIFY
    } cap_state_t;

endpackage

// File: rtl/vram_write_fifo.sv
// Small pending-write FIFO between the capture FSM and the shadow RAM write port.
// A push while full is dropped and latched in a sticky overflow flag, unless a pop frees a slot that same cycle.
module vram_write_fifo
    import romulator_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  vram_entry_t push_entry,
    input  logic        pop,
    output vram_entry_t head,
    output logic        full,
    output logic        empty,
    output logic        overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    vram_entry_t        slot_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               do_pop, do_push;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign head     = slot_q[rd_ptr_q];
    assign overflow = overflow_q;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
        if (push && !do_push) begin
            overflow_d = 1'b1;
        end
        if (!rst_n) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        rd_ptr_q   <= rd_ptr_d;
        wr_ptr_q   <= wr_ptr_d;
        count_q    <= count_d;
        overflow_q <= overflow_d;
    end

    // Storage is left unreset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push && rst_n) begin
            slot_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: rtl/vram_capture.sv
// Snoops CPU writes into the VRAM window and mirrors them into a 2 KiB shadow RAM for diagnostics readout.
// Optional feature macro: VRAM_CAPTURE_STATS_EN adds the capture_count output.
module vram_capture
    import romulator_pkg::*;
#(
    parameter logic [15:0] VRAM_BASE   = 16'h8000,
    parameter logic [10:0] SIZE_NARROW = 11'd1000,
    parameter logic [10:0] SIZE_WIDE   = 11'd2000,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        fpga_clk,
    input  logic        fpga_reset,
    input  logic        cpu_phi2,
    input  logic        cpu_rwb,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data,
    input  logic        wide_mode,
    input  logic [10:0] vram_address,
    input  logic        vram_read_clock,
    output logic [7:0]  vram_data,
    output logic [10:0] vram_size,
    output logic        fifo_overflow
`ifdef VRAM_CAPTURE_STATS_EN
    ,
    output logic [15:0] capture_count
`endif
);

    localparam int SYNC_W = 1 + $bits(cpu_bus_t);

    // phi2 and the bus share one pipeline so they stay cycle-aligned.
    logic [1:0][SYNC_W-1:0] sync_q, sync_d;
    logic                   s_phi2;
    cpu_bus_t               s_bus;

    always_comb begin
        sync_d[0] = {cpu_phi2, cpu_rwb, cpu_address, cpu_data};
        sync_d[1] = sync_q[0];
        if (!fpga_reset) begin
            sync_d = '0;
        end
    end

    always_ff @(posedge fpga_clk) begin
        sync_q <= sync_d;
    end

    assign s_phi2 = sync_q[1][SYNC_W-1];
    assign s_bus  = cpu_bus_t'(sync_q[1][SYNC_W-2:0]);

    cap_state_t  state_q;
    cpu_bus_t    last_bus_q;
    logic        push_q;
    vram_entry_t push_entry_q;
    logic [15:0] bus_offset;
    logic        bus_qualifies;

    // Unsigned wrap makes addresses below the base land far outside the window.
    assign bus_offset    = last_bus_q.address - VRAM_BASE;
    assign bus_qualifies = !last_bus_q.rwb && (bus_offset < 16'(VRAM_WINDOW_BYTES));

    always_ff @(posedge fpga_clk) begin
        if (!fpga_reset) begin
            state_q      <= CAP_IDLE;
            last_bus_q   <= '0;
            push_q       <= 1'b0;
            push_entry_q <= '0;
        end else begin
            push_q <= 1'b0;
            case (state_q)
                CAP_IDLE: begin
                    if (s_phi2) begin
                        last_bus_q <= s_bus;
                        state_q    <= CAP_SAMPLE;
                    end
                end
                CAP_SAMPLE: begin
                    if (s_phi2) begin
                        last_bus_q <= s_bus;
                    end else begin
                        state_q      <= CAP_QUALIFY;
                        push_q       <= bus_qualifies;
                        push_entry_q <= {bus_offset[10:0], last_bus_q.data};
                    end
                end
                CAP_QUALIFY: state_q <= CAP_IDLE;
                default:     state_q <= CAP_IDLE;
            endcase
        end
    end

    vram_entry_t fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;

    assign fifo_pop = !fifo_empty && !vram_read_clock;

    vram_write_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (fpga_clk),
        .rst_n      (fpga_reset),
        .push       (push_q),
        .push_entry (push_entry_q),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .overflow   (fifo_overflow)
    );

    logic [7:0] mem [VRAM_WINDOW_BYTES];
    logic [7:0] vram_data_q;

    always_ff @(posedge fpga_clk) begin
        if (fifo_pop) begin
            mem[fifo_head.offset] <= fifo_head.data;
        end
    end

    // Read-before-write: a same-cycle write to the read address returns the old byte.
    always_ff @(posedge fpga_clk) begin
        if (!fpga_reset) begin
            vram_data_q <= '0;
        end else begin
            vram_data_q <= mem[vram_address];
        end
    end

    assign vram_data = vram_data_q;
    assign vram_size = wide_mode ? SIZE_WIDE : SIZE_NARROW;

`ifdef VRAM_CAPTURE_STATS_EN
    logic [15:0] capture_count_q, capture_count_d;

    always_comb begin
        capture_count_d = capture_count_q + (push_q ? 16'd1 : 16'd0);
        if (!fpga_reset) begin
            capture_count_d = '0;
        end
    end

    always_ff @(posedge fpga_clk) begin
        capture_count_q <= capture_count_d;
    end

    assign capture_count = capture_count_q;
`endif

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_vram_capture.sv
// Self-checking bench for vram_capture: scoreboard of expected shadow-RAM bytes, checked through the read port.
module tb_vram_capture;

    logic        fpga_clk = 1'b0;
    logic        fpga_reset = 1'b1;
    logic        cpu_phi2 = 1'b0;
    logic        cpu_rwb = 1'b1;
    logic [15:0] cpu_address = 16'h0000;
    logic [7:0]  cpu_data = 8'h00;
    logic        wide_mode = 1'b0;
    logic [10:0] vram_address = 11'd0;
    logic        vram_read_clock = 1'b0;
    logic [7:0]  vram_data;
    logic [10:0] vram_size;
    logic        fifo_overflow;
`ifdef VRAM_CAPTURE_STATS_EN
    logic [15:0] capture_count;
`endif

    vram_capture dut (
        .fpga_clk        (fpga_clk),
        .fpga_reset      (fpga_reset),
        .cpu_phi2        (cpu_phi2),
        .cpu_rwb         (cpu_rwb),
        .cpu_address     (cpu_address),
        .cpu_data        (cpu_data),
        .wide_mode       (wide_mode),
        .vram_address    (vram_address),
        .vram_read_clock (vram_read_clock),
        .vram_data       (vram_data),
        .vram_size       (vram_size),
        .fifo_overflow   (fifo_overflow)
`ifdef VRAM_CAPTURE_STATS_EN
        ,
        .capture_count   (capture_count)
`endif
    );

    always #5 fpga_clk = ~fpga_clk;

    typedef struct {
        logic [10:0] off;
        logic [7:0]  data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_mem [2048];
    int         n_cmp = 0;
    int         n_err = 0;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cpu_bus_cycle(input logic rwb, input logic [15:0] addr,
                                 input logic [7:0] data, input int post);
        @(negedge fpga_clk);
        cpu_rwb     = rwb;
        cpu_address = addr;
        cpu_data    = data;
        cpu_phi2    = 1'b1;
        repeat (6) @(negedge fpga_clk);
        cpu_phi2 = 1'b0;
        repeat (post) @(negedge fpga_clk);
        cpu_rwb = 1'b1;
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data, input bit lands);
        cpu_bus_cycle(1'b0, addr, data, 6);
        if (lands && addr >= 16'h8000 && addr <= 16'h87FF) begin
            model_mem[addr - 16'h8000] = data;
        end
    endtask

    task automatic expect_off(input logic [10:0] off);
        sb.push_back('{off: off, data: model_mem[off]});
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge fpga_clk);
            vram_address = e.off;
            @(negedge fpga_clk);
            n_cmp++;
            if (vram_data !== e.data) begin
                n_err++;
                $display("FAIL %s off=%0d got=%02h want=%02h", tag, e.off, vram_data, e.data);
            end else begin
                $display("ok   %s off=%0d data=%02h", tag, e.off, vram_data);
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge fpga_clk);
        fpga_reset = 1'b0;
        repeat (2) @(negedge fpga_clk);
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (vram_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_vram_data got=%02h want=00", vram_data);
        end else $display("ok   reset_vram_data");
        n_cmp++;
        if (fifo_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_overflow got=%b want=0", fifo_overflow);
        end else $display("ok   reset_overflow");
`ifdef VRAM_CAPTURE_STATS_EN
        n_cmp++;
        if (capture_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_capture_count got=%0d want=0", capture_count);
        end else $display("ok   reset_capture_count");
`endif
        fpga_reset = 1'b1;
        wide_mode  = 1'b0;
        #1;
        n_cmp++;
        if (vram_size !== 11'd1000) begin
            n_err++;
            $display("FAIL size_narrow got=%0d want=1000", vram_size);
        end else $display("ok   size_narrow");
        wide_mode = 1'b1;
        #1;
        n_cmp++;
        if (vram_size !== 11'd2000) begin
            n_err++;
            $display("FAIL size_wide got=%0d want=2000", vram_size);
        end else $display("ok   size_wide");
        wide_mode = 1'b0;
    endtask

    task automatic test_latency();
        bit found = 1'b0;
        cpu_write(16'h8005, 8'h00, 1'b1);
        @(negedge fpga_clk);
        vram_address = 11'd5;
        cpu_bus_cycle(1'b0, 16'h8005, 8'h41, 0);
        for (int k = 0; k < 6 && !found; k++) begin
            @(negedge fpga_clk);
            if (vram_data === 8'h41) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL latency got=%02h want=41 within 6 cycles", vram_data);
        end else $display("ok   latency data=41");
        model_mem[5] = 8'h41;
        repeat (6) @(negedge fpga_clk);
    endtask

    task automatic test_boundary();
        cpu_write(16'h8000, 8'h11, 1'b1);
        cpu_write(16'h87FF, 8'hAA, 1'b1);
        cpu_write(16'h8800, 8'h55, 1'b1);
        cpu_write(16'h7FFF, 8'h66, 1'b1);
        expect_off(11'd2047);
        expect_off(11'd0);
        drain("boundary");
    endtask

    task automatic test_read_window();
        for (int i = 0; i < 4; i++) cpu_write(16'h8000 + 16'(i), 8'h30 + 8'(i), 1'b1);
        for (int i = 0; i < 4; i++) expect_off(11'(i));
        @(negedge fpga_clk);
        vram_read_clock = 1'b1;
        for (int i = 0; i < 4; i++) cpu_write(16'h8000 + 16'(i), 8'hE0 + 8'(i), 1'b1);
        drain("held_unchanged");
        @(negedge fpga_clk);
        vram_read_clock = 1'b0;
        repeat (4) @(negedge fpga_clk);
        for (int i = 0; i < 4; i++) expect_off(11'(i));
        drain("released");
        n_cmp++;
        if (fifo_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL no_overflow got=%b want=0", fifo_overflow);
        end else $display("ok   no_overflow");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) cpu_write(16'h8008 + 16'(i), 8'hC0 + 8'(i), 1'b1);
        apply_reset();
        fpga_reset = 1'b1;
        @(negedge fpga_clk);
        vram_read_clock = 1'b1;
        for (int i = 0; i < 5; i++) cpu_write(16'h8008 + 16'(i), 8'hD0 + 8'(i), i < 4);
        n_cmp++;
        if (fifo_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_flag got=%b want=1", fifo_overflow);
        end else $display("ok   overflow_flag");
`ifdef VRAM_CAPTURE_STATS_EN
        n_cmp++;
        if (capture_count !== 16'd5) begin
            n_err++;
            $display("FAIL capture_count got=%0d want=5", capture_count);
        end else $display("ok   capture_count=5");
`endif
        @(negedge fpga_clk);
        vram_read_clock = 1'b0;
        repeat (4) @(negedge fpga_clk);
        for (int i = 0; i < 5; i++) expect_off(11'(8 + i));
        drain("overflow");
    endtask

    task automatic test_cpu_read();
        cpu_write(16'h8010, 8'h77, 1'b1);
        cpu_bus_cycle(1'b1, 16'h8010, 8'h99, 6);
        expect_off(11'h010);
        drain("cpu_read");
    endtask

    task automatic test_back_to_back();
        logic [10:0] offs [8];
        for (int i = 0; i < 8; i++) begin
            offs[i] = 11'($urandom_range(0, 2047));
            cpu_write(16'h8000 + 16'(offs[i]), 8'($urandom_range(0, 255)), 1'b1);
        end
        for (int i = 0; i < 8; i++) expect_off(offs[i]);
        drain("back_to_back");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_boundary();
        test_read_window();
        test_overflow();
        test_cpu_read();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
